// File: rtl/rv32_ifetch_pkg.sv
// rtl/rv32_ifetch_pkg.sv - shared types and constants for the instruction fetch unit
package rv32_ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

endpackage

// File: rtl/rv32_ifetch_if.sv
// rtl/rv32_ifetch_if.sv - code-memory and decode-side signals of the fetch unit
interface rv32_ifetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
    input  imem_ack, imem_rdata, imem_err, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
    output imem_ack, imem_rdata, imem_err, if_ready
  );

endinterface

// File: rtl/rv32_ifetch_fifo.sv
// rtl/rv32_ifetch_fifo.sv - instruction buffer with synchronous clear
module rv32_ifetch_fifo
  import rv32_ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output logic   empty,
  output logic   full,
  output entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Clear wins over any same-cycle push or pop.
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rv32_ifetch.sv
// rtl/rv32_ifetch.sv - single-outstanding instruction fetch with a small decode buffer
module rv32_ifetch #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = rv32_ifetch_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           flush,
  input  logic [31:0]    pc,
  output logic           busy,
  rv32_ifetch_if.master  bus
);

  import rv32_ifetch_pkg::*;

  state_t      state;
  state_t      state_n;
  logic        load_addr;
  logic        push;
  logic [31:0] addr_q;
  entry_t      wdata;
  entry_t      head;
  logic        empty;
  logic        full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         addr_q <= '0;
    else if (load_addr) addr_q <= pc;
  end

  // busy drops only on the cycle a response is accepted into the buffer.
  always_comb begin
    state_n   = state;
    load_addr = 1'b0;
    push      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        if (enable && !flush && !full) begin
          state_n   = WAIT;
          load_addr = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          state_n = IDLE;
          if (!flush) begin
            push = 1'b1;
            busy = 1'b0;
          end
        end else if (flush) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wdata.pc    = addr_q;
  assign wdata.instr = bus.imem_err ? NOP_INSTR : bus.imem_rdata;
  assign wdata.fault = bus.imem_err;

  rv32_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (bus.if_valid && bus.if_ready),
    .wdata (wdata),
    .empty (empty),
    .full  (full),
    .head  (head)
  );

  // Head fields are gated so stale storage never shows while the buffer is empty.
  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = !empty;
  assign bus.if_instr  = empty ? '0 : head.instr;
  assign bus.if_pc     = empty ? '0 : head.pc;
  assign bus.if_fault  = !empty && head.fault;

endmodule

// File: tb/tb_rv32_ifetch.sv
// tb/tb_rv32_ifetch.sv - directed self-checking bench for rv32_ifetch
module tb_rv32_ifetch;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic [31:0] pc;
  logic        busy;
  int          total;
  int          bad;

  rv32_ifetch_if bus();

  rv32_ifetch dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .flush  (flush),
    .pc     (pc),
    .busy   (busy),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    enable = 1'b0;
    flush  = 1'b0;
    pc     = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.imem_err   = 1'b0;
    bus.if_ready   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc",    bus.if_pc, 32'd0);
    chk("rst_fault", 32'(bus.if_fault), 32'd0);
    chk("rst_busy",  32'(busy), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Zero-wait memory, three back-to-back fetches
    enable = 1'b1;
    bus.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'(k * 4);
      #1;
      chk("zw_idle_req",  32'(bus.imem_req), 32'd0);
      chk("zw_idle_busy", 32'(busy), 32'd1);
      if (k > 0) begin
        chk("zw_head_pc",    bus.if_pc, 32'((k - 1) * 4));
        chk("zw_head_instr", bus.if_instr, 32'hA000_0000 + 32'(k - 1));
      end
      cyc();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hA000_0000 + 32'(k);
      #1;
      chk("zw_wait_req",  32'(bus.imem_req), 32'd1);
      chk("zw_wait_addr", bus.imem_addr, 32'(k * 4));
      chk("zw_wait_busy", 32'(busy), 32'd0);
      cyc();
      bus.imem_ack = 1'b0;
    end
    enable = 1'b0;
    #1;
    chk("zw_last_valid", 32'(bus.if_valid), 32'd1);
    chk("zw_last_pc",    bus.if_pc, 32'd8);
    chk("zw_last_instr", bus.if_instr, 32'hA000_0002);
    cyc();
    chk("zw_drained", 32'(bus.if_valid), 32'd0);
    chk("zw_no_req",  32'(bus.imem_req), 32'd0);

    // Ack after three wait cycles, enable dropped mid-request
    enable = 1'b1;
    pc = 32'h100;
    cyc();
    enable = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("slow_req",  32'(bus.imem_req), 32'd1);
      chk("slow_addr", bus.imem_addr, 32'h100);
      chk("slow_busy", 32'(busy), 32'd1);
      cyc();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    #1;
    chk("slow_ack_busy", 32'(busy), 32'd0);
    cyc();
    bus.imem_ack = 1'b0;
    #1;
    chk("slow_busy_after", 32'(busy), 32'd1);
    chk("slow_req_after",  32'(bus.imem_req), 32'd0);
    chk("slow_valid",      32'(bus.if_valid), 32'd1);
    chk("slow_pc",         bus.if_pc, 32'h100);
    chk("slow_instr",      bus.if_instr, 32'h1234_5678);
    cyc();
    chk("slow_drained", 32'(bus.if_valid), 32'd0);

    // Full buffer stalls issue until a pop
    enable = 1'b1;
    bus.if_ready = 1'b0;
    pc = 32'h200;
    cyc();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_00B0;
    cyc();
    bus.imem_ack = 1'b0;
    pc = 32'h204;
    cyc();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_00B1;
    cyc();
    bus.imem_ack = 1'b0;
    pc = 32'h208;
    #1;
    chk("full_req0",  32'(bus.imem_req), 32'd0);
    chk("full_busy",  32'(busy), 32'd1);
    chk("full_head",  bus.if_pc, 32'h200);
    cyc();
    chk("full_req1",  32'(bus.imem_req), 32'd0);
    bus.if_ready = 1'b1;
    cyc();
    bus.if_ready = 1'b0;
    #1;
    chk("pop_req",  32'(bus.imem_req), 32'd0);
    chk("pop_head", bus.if_pc, 32'h204);
    cyc();
    chk("reissue_req",  32'(bus.imem_req), 32'd1);
    chk("reissue_addr", bus.imem_addr, 32'h208);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_00B2;
    cyc();
    bus.imem_ack = 1'b0;
    enable = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    chk("drain_pc0",    bus.if_pc, 32'h204);
    chk("drain_instr0", bus.if_instr, 32'h0000_00B1);
    cyc();
    chk("drain_pc1",    bus.if_pc, 32'h208);
    chk("drain_instr1", bus.if_instr, 32'h0000_00B2);
    cyc();
    chk("drain_empty", 32'(bus.if_valid), 32'd0);

    // Flush during WAIT, late response is dropped
    enable = 1'b1;
    pc = 32'h300;
    cyc();
    flush = 1'b1;
    #1;
    chk("fl_wait_req",  32'(bus.imem_req), 32'd1);
    chk("fl_wait_busy", 32'(busy), 32'd1);
    cyc();
    flush = 1'b0;
    pc = 32'h400;
    #1;
    chk("drop_req",  32'(bus.imem_req), 32'd1);
    chk("drop_addr", bus.imem_addr, 32'h300);
    chk("drop_busy", 32'(busy), 32'd1);
    cyc();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_ack_busy", 32'(busy), 32'd1);
    chk("drop_ack_addr", bus.imem_addr, 32'h300);
    cyc();
    bus.imem_ack = 1'b0;
    #1;
    chk("drop_valid", 32'(bus.if_valid), 32'd0);
    chk("drop_idle",  32'(bus.imem_req), 32'd0);
    cyc();
    chk("newpc_req",  32'(bus.imem_req), 32'd1);
    chk("newpc_addr", bus.imem_addr, 32'h400);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0044;
    #1;
    chk("newpc_busy", 32'(busy), 32'd0);
    cyc();
    bus.imem_ack = 1'b0;
    enable = 1'b0;
    #1;
    chk("newpc_valid", 32'(bus.if_valid), 32'd1);
    chk("newpc_pc",    bus.if_pc, 32'h400);
    chk("newpc_instr", bus.if_instr, 32'h0000_0044);
    cyc();

    // Bus error substitutes a NOP, then flush empties the buffer
    enable = 1'b1;
    bus.if_ready = 1'b0;
    pc = 32'h40;
    cyc();
    bus.imem_ack   = 1'b1;
    bus.imem_err   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    cyc();
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
    enable = 1'b0;
    #1;
    chk("err_valid", 32'(bus.if_valid), 32'd1);
    chk("err_pc",    bus.if_pc, 32'h40);
    chk("err_instr", bus.if_instr, 32'h0000_0013);
    chk("err_fault", 32'(bus.if_fault), 32'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(bus.if_valid), 32'd0);
    chk("flush_fault", 32'(bus.if_fault), 32'd0);

    // Reset asserted mid-WAIT
    enable = 1'b1;
    pc = 32'h500;
    cyc();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_00C0;
    cyc();
    bus.imem_ack = 1'b0;
    pc = 32'h504;
    cyc();
    chk("prerst_req",   32'(bus.imem_req), 32'd1);
    chk("prerst_valid", 32'(bus.if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req",   32'(bus.imem_req), 32'd0);
    chk("midrst_valid", 32'(bus.if_valid), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd1);
    chk("midrst_addr",  bus.imem_addr, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("postrst_idle", 32'(bus.imem_req), 32'd0);
    cyc();
    chk("postrst_req",  32'(bus.imem_req), 32'd1);
    chk("postrst_addr", bus.imem_addr, 32'h504);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_00C1;
    cyc();
    bus.imem_ack = 1'b0;
    enable = 1'b0;
    #1;
    chk("postrst_pc",    bus.if_pc, 32'h504);
    chk("postrst_instr", bus.if_instr, 32'h0000_00C1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
